// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush and mult/div freeze.
// The mult/div path (MDWAIT/MDDONE states, stall counter) exists only when HAZARD_MULDIV_EN is defined.
module hazard_ctrl #(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [4:0] IdRs,
   input  logic [4:0] IdRt,
   input  logic       IdUsesRs,
   input  logic       IdUsesRt,
   input  logic       ExMemRead,
   input  logic       ExRegWrite,
   input  logic [4:0] ExRd,
   input  logic       BranchTaken,
   input  logic       MulDivStart,
   output logic       PcEn,
   output logic       IfIdEn,
   output logic       IfIdFlush,
   output logic       IdExEn,
   output logic       IdExFlush,
   output logic       ExMemFlush,
   output logic       MulDivDone,
   output logic       Busy
);

   logic lu;

   assign lu = ExMemRead & ExRegWrite & (ExRd != 5'd0) &
               ((IdUsesRs & (IdRs == ExRd)) | (IdUsesRt & (IdRt == ExRd)));

`ifdef HAZARD_MULDIV_EN
   localparam int CNT_W = $clog2(MULDIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      MDWAIT = 2'd1,
      MDDONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d    = state_q;
      cnt_d      = cnt_q;
      PcEn       = 1'b1;
      IfIdEn     = 1'b1;
      IfIdFlush  = 1'b0;
      IdExEn     = 1'b1;
      IdExFlush  = 1'b0;
      ExMemFlush = 1'b0;
      MulDivDone = 1'b0;
      Busy       = 1'b0;

      case (state_q)
         MDWAIT: begin
            PcEn       = 1'b0;
            IfIdEn     = 1'b0;
            IdExEn     = 1'b0;
            ExMemFlush = 1'b1;
            Busy       = 1'b1;
            cnt_d      = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = MDDONE;
         end
         RUN, MDDONE: begin
            // In MDDONE the finished mult/div is still in EX, so its start flag must not retrigger.
            if (state_q == MDDONE) begin
               MulDivDone = 1'b1;
               state_d    = RUN;
            end
            if ((state_q == RUN) && MulDivStart) begin
               PcEn       = 1'b0;
               IfIdEn     = 1'b0;
               IdExEn     = 1'b0;
               ExMemFlush = 1'b1;
               Busy       = 1'b1;
               cnt_d      = CNT_LOAD;
               state_d    = MDWAIT;
            end else if (BranchTaken) begin
               IfIdFlush  = 1'b1;
               IdExFlush  = 1'b1;
            end else if (lu) begin
               PcEn       = 1'b0;
               IfIdEn     = 1'b0;
               IdExFlush  = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase

      if (!Rst_n) begin
         PcEn       = 1'b0;
         IfIdEn     = 1'b0;
         IfIdFlush  = 1'b0;
         IdExEn     = 1'b0;
         IdExFlush  = 1'b0;
         ExMemFlush = 1'b0;
         MulDivDone = 1'b0;
         Busy       = 1'b0;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`else
   // Without the mult/div path the block is purely combinational.
   logic unused_in;
   assign unused_in = ^{Clk, MulDivStart, MULDIV_CYCLES[0]};

   always_comb begin
      PcEn       = 1'b1;
      IfIdEn     = 1'b1;
      IfIdFlush  = 1'b0;
      IdExEn     = 1'b1;
      IdExFlush  = 1'b0;
      ExMemFlush = 1'b0;
      MulDivDone = 1'b0;
      Busy       = 1'b0;

      if (BranchTaken) begin
         IfIdFlush = 1'b1;
         IdExFlush = 1'b1;
      end else if (lu) begin
         PcEn      = 1'b0;
         IfIdEn    = 1'b0;
         IdExFlush = 1'b1;
      end

      if (!Rst_n) begin
         PcEn      = 1'b0;
         IfIdEn    = 1'b0;
         IfIdFlush = 1'b0;
         IdExEn    = 1'b0;
         IdExFlush = 1'b0;
      end
   end
`endif

endmodule
